// File: rtl/checkpoint_monitor.sv
// rtl/checkpoint_monitor.sv - ordered signature-sequence progress monitor
//
// Purpose: watches a status bus for an ordered sequence of up to NUM_CHK
// signature codes and reports pass, fail (timeout / skipped checkpoint)
// with a cycle budget, glitch filtering and progress readback.
//
// Optional feature macro: CHKMON_STRICT_EN
//   defined   - a stable, unconsumed bus value equal to a later checkpoint
//               of the active sequence fails the run with code 2'b10.
//   undefined - only sig[idx] is considered; other values are ignored.
//
// Ports:
//   clock        single clock domain
//   resetb       asynchronous active-low reset
//   start_i      one-cycle pulse, arms the monitor from IDLE
//   clear_i      synchronous return to IDLE from any state
//   num_i        active checkpoint count, 0..NUM_CHK
//   sig_i        packed signatures, sig[k] = sig_i[k*WIDTH +: WIDTH]
//   timeout_i    cycle budget, 0 disables the timeout
//   mon_i        monitored bus (may glitch)
//   busy_o       high while ARMED
//   pass_o       high in PASS
//   fail_o       high in FAIL
//   fail_code_o  00 none, 01 timeout, 10 skipped checkpoint
//   idx_o        checkpoints matched so far
//   elapsed_o    cycles spent in ARMED, frozen in PASS/FAIL
module checkpoint_monitor #(
  parameter int WIDTH         = 16,
  parameter int NUM_CHK       = 4,
  parameter int STABLE_CYCLES = 2,
  parameter int TIMER_W       = 24
) (
  input  logic                          clock,
  input  logic                          resetb,
  input  logic                          start_i,
  input  logic                          clear_i,
  input  logic [$clog2(NUM_CHK+1)-1:0]  num_i,
  input  logic [NUM_CHK*WIDTH-1:0]      sig_i,
  input  logic [TIMER_W-1:0]            timeout_i,
  input  logic [WIDTH-1:0]              mon_i,
  output logic                          busy_o,
  output logic                          pass_o,
  output logic                          fail_o,
  output logic [1:0]                    fail_code_o,
  output logic [$clog2(NUM_CHK+1)-1:0]  idx_o,
  output logic [TIMER_W-1:0]            elapsed_o
);

  localparam int IW = $clog2(NUM_CHK + 1);
  localparam int RW = $clog2(STABLE_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    PASS  = 2'd2,
    FAIL  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   mon_q;
  logic [RW-1:0]      run_q, run_d;
  logic               consumed_q, consumed_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [TIMER_W-1:0] timer_q, timer_d;
  logic [1:0]         code_q, code_d;

  logic [WIDTH-1:0]   cur_sig;
  logic               mon_change;
  logic               stable;
  logic               hit;
  logic               timeout_hit;
  logic               skip;

  assign mon_change = (mon_i != mon_q);

  // A value counts only once it has been held long enough and has not
  // already produced a hit; consumption lasts until the bus changes.
  assign stable = (run_q == RW'(STABLE_CYCLES)) && !consumed_q;

  always_comb begin
    cur_sig = '0;
    for (int k = 0; k < NUM_CHK; k++) begin
      if (idx_q == IW'(k)) cur_sig = sig_i[k*WIDTH +: WIDTH];
    end
  end

  assign hit = (state_q == ARMED) && stable && (idx_q < num_i) && (mon_q == cur_sig);

  // ">=" rather than "==" so a timeout deferred by a simultaneous hit
  // still fires on the following cycle.
  assign timeout_hit = (timeout_i != '0) &&
                       (({1'b0, timer_q} + {{TIMER_W{1'b0}}, 1'b1}) >= {1'b0, timeout_i});

`ifdef CHKMON_STRICT_EN
  always_comb begin
    skip = 1'b0;
    for (int j = 0; j < NUM_CHK; j++) begin
      if ((IW'(j) > idx_q) && (IW'(j) < num_i) && (mon_q == sig_i[j*WIDTH +: WIDTH])) begin
        skip = 1'b1;
      end
    end
    skip = skip && stable && (state_q == ARMED);
  end
`else
  assign skip = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    timer_d = timer_q;
    code_d  = code_q;
    run_d   = mon_change ? RW'(1) :
              (run_q == RW'(STABLE_CYCLES)) ? run_q : run_q + RW'(1);
    if (mon_change)  consumed_d = 1'b0;
    else if (hit)    consumed_d = 1'b1;
    else             consumed_d = consumed_q;

    if (clear_i) begin
      state_d = IDLE;
      idx_d   = '0;
      timer_d = '0;
      code_d  = 2'b00;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            idx_d      = '0;
            timer_d    = '0;
            code_d     = 2'b00;
            consumed_d = 1'b0;
            state_d    = (num_i == '0) ? PASS : ARMED;
          end
        end
        ARMED: begin
          timer_d = (&timer_q) ? timer_q : timer_q + TIMER_W'(1);
          if (hit) begin
            idx_d = idx_q + IW'(1);
            if ((idx_q + IW'(1)) == num_i) state_d = PASS;
          end else if (timeout_hit) begin
            state_d = FAIL;
            code_d  = 2'b01;
          end else if (skip) begin
            state_d = FAIL;
            code_d  = 2'b10;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_q    <= IDLE;
      mon_q      <= '0;
      run_q      <= '0;
      consumed_q <= 1'b0;
      idx_q      <= '0;
      timer_q    <= '0;
      code_q     <= 2'b00;
    end else begin
      state_q    <= state_d;
      mon_q      <= mon_i;
      run_q      <= run_d;
      consumed_q <= consumed_d;
      idx_q      <= idx_d;
      timer_q    <= timer_d;
      code_q     <= code_d;
    end
  end

  assign busy_o      = (state_q == ARMED);
  assign pass_o      = (state_q == PASS);
  assign fail_o      = (state_q == FAIL);
  assign fail_code_o = code_q;
  assign idx_o       = idx_q;
  assign elapsed_o   = timer_q;

endmodule

// File: tb/tb_checkpoint_monitor.sv
// tb/tb_checkpoint_monitor.sv - scoreboard bench for checkpoint_monitor
module tb_checkpoint_monitor;

  logic        clock = 1'b0;
  logic        resetb;
  logic        start_i, clear_i;
  logic [2:0]  num_i;
  logic [63:0] sig_i;
  logic [23:0] timeout_i;
  logic [15:0] mon_i;
  logic        busy_o, pass_o, fail_o;
  logic [1:0]  fail_code_o;
  logic [2:0]  idx_o;
  logic [23:0] elapsed_o;

  checkpoint_monitor #(
    .WIDTH(16), .NUM_CHK(4), .STABLE_CYCLES(2), .TIMER_W(24)
  ) dut (
    .clock(clock), .resetb(resetb), .start_i(start_i), .clear_i(clear_i),
    .num_i(num_i), .sig_i(sig_i), .timeout_i(timeout_i), .mon_i(mon_i),
    .busy_o(busy_o), .pass_o(pass_o), .fail_o(fail_o),
    .fail_code_o(fail_code_o), .idx_o(idx_o), .elapsed_o(elapsed_o)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0]  st;
    logic [23:0] el;
    bit          chk_el;
    string       nm;
  } exp_t;

  exp_t       exp_q[$];
  int         compared   = 0;
  int         mismatched = 0;
  int         probe_req  = 0;
  int         probe_done = 0;
  bit         mon_en     = 0;
  logic [7:0] last_st    = 8'h00;

  // status word: {busy, pass, fail, code[1:0], idx[2:0]}
  task automatic expect_st(input bit b, input bit p, input bit f, input logic [1:0] c,
                           input logic [2:0] i, input int el, input bit chk, input string nm);
    exp_t e;
    e.st = {b, p, f, c, i};
    e.el = 24'(el);
    e.chk_el = chk;
    e.nm = nm;
    exp_q.push_back(e);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic probe(input bit b, input bit p, input bit f, input logic [1:0] c,
                       input logic [2:0] i, input int el, input bit chk, input string nm);
    @(posedge clock);
    #1;
    expect_st(b, p, f, c, i, el, chk, nm);
    probe_req++;
    @(negedge clock);
  endtask

  // Monitor: every change in reported status, and every probe request,
  // consumes the next expected record.
  always @(negedge clock) begin
    logic [7:0] st;
    exp_t       e;
    bit         ev;
    if (mon_en) begin
      st = {busy_o, pass_o, fail_o, fail_code_o, idx_o};
      ev = (st != last_st) || (probe_req != probe_done);
      probe_done = probe_req;
      last_st = st;
      if (ev) begin
        compared++;
        if (exp_q.size() == 0) begin
          mismatched++;
          $display("FAIL unexpected: got st=%b elapsed=%0d, want no event", st, elapsed_o);
        end else begin
          e = exp_q.pop_front();
          if (st !== e.st || (e.chk_el && elapsed_o !== e.el)) begin
            mismatched++;
            $display("FAIL %s: got st=%b elapsed=%0d, want st=%b elapsed=%0d",
                     e.nm, st, elapsed_o, e.st, e.el);
          end
        end
      end
    end
  end

  initial begin
    resetb = 1'b0; start_i = 1'b0; clear_i = 1'b0; num_i = 3'd0;
    sig_i = 64'h0; timeout_i = 24'd0; mon_i = 16'h0;
    cyc(1);
    mon_en = 1;
    probe(0, 0, 0, 2'b00, 3'd0, 0, 1, "reset_state");
    resetb = 1'b1;
    cyc(2);

    // basic two-checkpoint pass
    num_i = 3'd2; sig_i = {16'h0, 16'h0, 16'hAB61, 16'hAB60}; timeout_i = 24'd0;
    expect_st(1, 0, 0, 2'b00, 3'd0, 0, 1, "a_arm");
    expect_st(1, 0, 0, 2'b00, 3'd1, 3, 1, "a_idx1");
    expect_st(0, 1, 0, 2'b00, 3'd2, 6, 1, "a_pass");
    start_i = 1'b1; cyc(1); start_i = 1'b0;
    mon_i = 16'hAB60; cyc(3);
    mon_i = 16'hAB61; cyc(3);
    mon_i = 16'h0; cyc(2);
    start_i = 1'b1; cyc(1); start_i = 1'b0;
    probe(0, 1, 0, 2'b00, 3'd2, 6, 1, "a_frozen");
    expect_st(0, 0, 0, 2'b00, 3'd0, 0, 1, "a_clear");
    clear_i = 1'b1; cyc(1); clear_i = 1'b0; cyc(2);

    // single-cycle glitch must not count
    expect_st(1, 0, 0, 2'b00, 3'd0, 0, 1, "b_arm");
    start_i = 1'b1; cyc(1); start_i = 1'b0;
    cyc(2);
    mon_i = 16'hAB60; cyc(1);
    mon_i = 16'h0; cyc(4);
    probe(1, 0, 0, 2'b00, 3'd0, 0, 0, "b_glitch");
    expect_st(0, 0, 0, 2'b00, 3'd0, 0, 1, "b_clear");
    clear_i = 1'b1; cyc(1); clear_i = 1'b0; cyc(2);

    // timeout after one checkpoint
    timeout_i = 24'd100;
    expect_st(1, 0, 0, 2'b00, 3'd0, 0, 1, "c_arm");
    expect_st(1, 0, 0, 2'b00, 3'd1, 3, 1, "c_idx1");
    expect_st(0, 0, 1, 2'b01, 3'd1, 100, 1, "c_timeout");
    start_i = 1'b1; cyc(1); start_i = 1'b0;
    mon_i = 16'hAB60; cyc(105);
    probe(0, 0, 1, 2'b01, 3'd1, 100, 1, "c_frozen");
    expect_st(0, 0, 0, 2'b00, 3'd0, 0, 1, "c_clear");
    mon_i = 16'h0; clear_i = 1'b1; cyc(1); clear_i = 1'b0; cyc(2);

    // final hit coincides with budget: hit wins
    num_i = 3'd1; timeout_i = 24'd2;
    expect_st(1, 0, 0, 2'b00, 3'd0, 0, 1, "d_arm");
    expect_st(0, 1, 0, 2'b00, 3'd1, 2, 1, "d_pass");
    start_i = 1'b1; mon_i = 16'hAB60; cyc(1); start_i = 1'b0; cyc(4);
    expect_st(0, 0, 0, 2'b00, 3'd0, 0, 1, "d_clear");
    mon_i = 16'h0; clear_i = 1'b1; cyc(1); clear_i = 1'b0; cyc(2);

    // non-final hit coincides with budget: timeout one cycle later
    num_i = 3'd2;
    expect_st(1, 0, 0, 2'b00, 3'd0, 0, 1, "d2_arm");
    expect_st(1, 0, 0, 2'b00, 3'd1, 2, 1, "d2_idx1");
    expect_st(0, 0, 1, 2'b01, 3'd1, 3, 1, "d2_timeout");
    start_i = 1'b1; mon_i = 16'hAB60; cyc(1); start_i = 1'b0; cyc(5);
    expect_st(0, 0, 0, 2'b00, 3'd0, 0, 1, "d2_clear");
    mon_i = 16'h0; clear_i = 1'b1; cyc(1); clear_i = 1'b0; cyc(2);

    // later checkpoint seen first
    num_i = 3'd3; sig_i = {16'h0, 16'hAB62, 16'hAB61, 16'hAB60}; timeout_i = 24'd0;
    expect_st(1, 0, 0, 2'b00, 3'd0, 0, 1, "e_arm");
`ifdef CHKMON_STRICT_EN
    expect_st(0, 0, 1, 2'b10, 3'd0, 2, 1, "e_skip");
`endif
    start_i = 1'b1; mon_i = 16'hAB62; cyc(1); start_i = 1'b0; cyc(5);
`ifdef CHKMON_STRICT_EN
    probe(0, 0, 1, 2'b10, 3'd0, 2, 1, "e_skip_hold");
`else
    probe(1, 0, 0, 2'b00, 3'd0, 0, 0, "e_ignored");
`endif
    expect_st(0, 0, 0, 2'b00, 3'd0, 0, 1, "e_clear");
    mon_i = 16'h0; clear_i = 1'b1; cyc(1); clear_i = 1'b0; cyc(2);

    // async reset mid-run
    num_i = 3'd2; sig_i = {16'h0, 16'h0, 16'hAB61, 16'hAB60};
    expect_st(1, 0, 0, 2'b00, 3'd0, 0, 1, "f_arm");
    expect_st(1, 0, 0, 2'b00, 3'd1, 2, 1, "f_idx1");
    expect_st(0, 0, 0, 2'b00, 3'd0, 0, 1, "f_reset");
    start_i = 1'b1; mon_i = 16'hAB60; cyc(1); start_i = 1'b0; cyc(3);
    @(posedge clock);
    #2 resetb = 1'b0;
    @(negedge clock);
    cyc(1);
    resetb = 1'b1; mon_i = 16'h0;
    cyc(2);
    probe(0, 0, 0, 2'b00, 3'd0, 0, 1, "f_after_reset");

    // zero-length sequence, then clear and start together
    num_i = 3'd0;
    expect_st(0, 1, 0, 2'b00, 3'd0, 0, 1, "g_num0_pass");
    start_i = 1'b1; cyc(1); start_i = 1'b0; cyc(2);
    expect_st(0, 0, 0, 2'b00, 3'd0, 0, 1, "g_clear");
    num_i = 3'd2;
    clear_i = 1'b1; start_i = 1'b1; cyc(1); clear_i = 1'b0; start_i = 1'b0; cyc(2);
    probe(0, 0, 0, 2'b00, 3'd0, 0, 1, "g_clear_start");

    cyc(3);
    compared++;
    if (exp_q.size() != 0) begin
      mismatched++;
      $display("FAIL drain: got %0d pending records, want 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/checkpoint_monitor.md
Name: checkpoint_monitor

Overview:
Synthesizable progress monitor for the management-SoC/user-project boundary. Watches a GPIO-style status bus (e.g. mprj_io[31:16]) for an ordered sequence of up to NUM_CHK signature codes. Reports pass, fail and timeout in hardware, with a cycle budget, glitch filtering and progress readback. Generalises the single-pair checkpoint (0xAB60 -> 0xAB61) wait to N programmable, width-parametrised checkpoints with a bounded run time.

Parameters:
WIDTH, 16, width of monitored bus and of each signature
NUM_CHK, 4, maximum number of checkpoints in the sequence
STABLE_CYCLES, 2, consecutive sampled cycles a value must hold to count (>=1)
TIMER_W, 24, width of cycle budget / elapsed counter

Ports:
clock  input  1  single clock domain
resetb  input  1  asynchronous active-low reset
start_i  input  1  one-cycle pulse; arms monitor from IDLE
clear_i  input  1  synchronous return to IDLE from any state
num_i  input  $clog2(NUM_CHK+1)  active checkpoint count, 0..NUM_CHK
sig_i  input  NUM_CHK*WIDTH  signatures; sig[k] = sig_i[k*WIDTH +: WIDTH]
timeout_i  input  TIMER_W  cycle budget; 0 = no timeout
mon_i  input  WIDTH  monitored bus (asynchronous to program flow, may glitch)
busy_o  output  1  high in ARMED
pass_o  output  1  high in PASS (level)
fail_o  output  1  high in FAIL (level)
fail_code_o  output  2  00 none, 01 timeout, 10 skipped checkpoint
idx_o  output  $clog2(NUM_CHK+1)  checkpoints matched so far
elapsed_o  output  TIMER_W  cycles spent in ARMED; frozen on PASS/FAIL

Behaviour:
- Reset (resetb low, async): state IDLE; all outputs 0; mon_q, run_cnt, timer cleared.
- Sampling: mon_q <= mon_i every cycle in all states. run_cnt = consecutive cycles mon_q held its value. Set to 1 on change, saturating at STABLE_CYCLES.
- Hit: in ARMED, mon_q == sig[idx] and run_cnt == STABLE_CYCLES and value not yet consumed. After a hit, the held value is consumed; the next hit requires mon_q to change first, so equal adjacent signatures need distinct holds.
- Latency: with STABLE_CYCLES=1, mon_i valid before edge E0 -> idx_o increments at E1. Each extra stable cycle adds 1.
- States: IDLE, ARMED, PASS, FAIL.
- IDLE: start_i -> ARMED; idx=0, timer=0, fail_code=00. If num_i==0, go to PASS instead. start_i is ignored in all other states.
- ARMED: timer increments each cycle, saturating at all-ones. Hit -> idx+1. If idx+1 == num_i -> PASS.
- Timeout: when timeout_i != 0 and timer == timeout_i-1 and no hit that cycle -> FAIL, code 01. After timeout_i ARMED cycles, fail_o is high.
- Simultaneous hit and timeout: hit wins. If it was the final checkpoint -> PASS; otherwise idx advances and the timeout fires next cycle.
- PASS/FAIL: sticky until clear_i or reset. elapsed_o and idx_o frozen.
- clear_i: highest priority after reset. clear_i and start_i in the same cycle -> IDLE.
- sig_i, num_i and timeout_i are sampled continuously. They must be held stable while ARMED; changing them mid-run is undefined.

Optional Feature:
CHKMON_STRICT_EN
- Defined: in ARMED, a stable (run_cnt == STABLE_CYCLES), unconsumed mon_q equal to sig[j] for some idx < j < num_i is a skipped checkpoint -> FAIL, code 10. Hit on sig[idx] takes priority over the skip check.
- Undefined: values other than sig[idx] are ignored; code 10 is never produced.

Test Plan:
- num=2, sig={0xAB61,0xAB60}, timeout=0, STABLE=2: drive 0xAB60 3 cycles, then 0xAB61 3 cycles -> idx 0->1->2, pass_o=1, fail_code=00, elapsed_o frozen.
- One-cycle glitch of 0xAB60 between 0x0000 values, STABLE=2 -> no hit, idx_o stays 0, busy_o=1.
- num=2, timeout=100, only 0xAB60 driven -> idx=1, fail_o=1 with code 01, exactly 100 cycles after start, elapsed_o=100.
- Hit on final checkpoint on the same cycle the timer reaches the budget -> pass_o=1, fail_o=0.
- STRICT_EN, num=3, sig0=0xAB60, sig1=0xAB61, sig2=0xAB62: drive 0xAB62 first -> fail_o=1, code 10, idx_o=0. Without the macro: no fail, remains busy.
- resetb asserted mid-ARMED (idx=1) -> all outputs 0 immediately. clear_i in PASS -> IDLE. Then start_i with num=0 -> pass_o=1 one cycle later.
